// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and constants for the RAM port arbiter
package ode_mem_pkg;

    // Arbitration state: free round-robin or held by a single owner
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ  = 3;
    localparam int DEFAULT_MAX_LOCK = 64;

    // Requester slots on the shared RAM
    localparam int REQ_INTERP = 0;
    localparam int REQ_SOLVER = 1;
    localparam int REQ_HOST   = 2;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side bus of the RAM port arbiter
interface ram_port_arbiter_if
    import ode_mem_pkg::*;
#(
    parameter int NUM_REQ       = DEFAULT_NUM_REQ,
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = 16
);
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0]               req_we;
    logic [NUM_REQ-1:0]               req_lock;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WORD_SIZE-1:0]     req_wdata;
    logic [NUM_REQ-1:0]               gnt;
    logic [NUM_REQ-1:0]               rvalid;
    logic [WORD_SIZE-1:0]             rdata;
    logic                             lock_timeout;

    // Requesters drive the command fields and watch grant / read return
    modport master (
        output req, req_we, req_lock, req_addr, req_wdata,
        input  gnt, rvalid, rdata, lock_timeout
    );

    // The arbiter consumes the command fields and produces grant / read return
    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata,
        output gnt, rvalid, rdata, lock_timeout
    );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// rtl/ram_port_arbiter_rr_pick.sv - combinational round-robin priority picker
module rr_pick
    import ode_mem_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);

    // Lowest request at or above ptr wins; otherwise lowest request below ptr.
    // Later assignments override earlier ones, so the low group is scanned first.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (PTR_W'(i) < ptr)) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = PTR_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (PTR_W'(i) >= ptr)) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter with burst lock for the shared RAM
module ram_port_arbiter
    import ode_mem_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int NUM_REQ       = DEFAULT_NUM_REQ,
    parameter int MAX_LOCK      = DEFAULT_MAX_LOCK
) (
    input  logic                     clk,
    input  logic                     rst,
    ram_port_arbiter_if.slave        bus,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] ram_add2,
    output logic [ADDRESS_WIDTH-1:0] ram_add1,
    output logic [WORD_SIZE-1:0]     ram_wdata,
    input  logic [WORD_SIZE-1:0]     ram_data1
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK);

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   lock_cnt;
    logic [NUM_REQ-1:0] rd_pend;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [WORD_SIZE-1:0] rdata_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] gnt_c;
    logic [PTR_W-1:0]   win_idx;
    logic               xfer;
    logic               timeout;
    logic               sel_we;
    logic               sel_lock;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [WORD_SIZE-1:0]     sel_wdata;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Grant: owner only while locked, round-robin otherwise, nothing in reset
    always_comb begin
        gnt_c   = '0;
        win_idx = pick_idx;
        if (!rst) begin
            gnt_c = '0;
        end else if (state == LOCKED) begin
            gnt_c   = bus.req & (NUM_REQ'(1) << owner);
            win_idx = owner;
        end else begin
            gnt_c = pick_gnt;
        end
    end

    assign xfer      = |gnt_c;
    assign timeout   = (state == LOCKED) && (lock_cnt == CNT_W'(MAX_LOCK - 1));
    assign sel_we    = bus.req_we[win_idx];
    assign sel_lock  = bus.req_lock[win_idx];
    assign sel_addr  = bus.req_addr[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sel_wdata = bus.req_wdata[win_idx*WORD_SIZE +: WORD_SIZE];

    assign bus.gnt          = gnt_c;
    assign bus.rvalid       = rvalid_q;
    assign bus.rdata        = rdata_q;
    assign bus.lock_timeout = timeout;

    // Arbitration FSM, RAM command stage and two-stage read return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= UNLOCKED;
            ptr       <= '0;
            owner     <= '0;
            lock_cnt  <= '0;
            mem_write <= 1'b0;
            ram_add1  <= '0;
            ram_add2  <= '0;
            ram_wdata <= '0;
            rd_pend   <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            mem_write <= 1'b0;
            rd_pend   <= '0;
            if (xfer) begin
                mem_write <= sel_we;
                ram_add1  <= sel_addr;
                ram_add2  <= sel_addr;
                ram_wdata <= sel_wdata;
                if (!sel_we) begin
                    rd_pend <= gnt_c;
                end
            end

            // RAM read data is valid during the cycle after the command stage
            rvalid_q <= rd_pend;
            if (|rd_pend) begin
                rdata_q <= ram_data1;
            end

            case (state)
                UNLOCKED: begin
                    if (xfer) begin
                        ptr <= wrap_inc(win_idx);
                        if (sel_lock) begin
                            state    <= LOCKED;
                            owner    <= win_idx;
                            lock_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    // An owner transfer in the final cycle completes, the timeout still fires
                    if (timeout || (xfer && !sel_lock)) begin
                        state    <= UNLOCKED;
                        ptr      <= wrap_inc(owner);
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= UNLOCKED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for the RAM port arbiter
module tb_ram_port_arbiter;
    import ode_mem_pkg::*;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int AW = 16;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_write;
    logic [AW-1:0] ram_add1, ram_add2;
    logic [W-1:0]  ram_wdata, ram_data1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ram_port_arbiter_if #(.NUM_REQ(N), .WORD_SIZE(W), .ADDRESS_WIDTH(AW)) bus ();

    ram_port_arbiter #(
        .WORD_SIZE(W), .ADDRESS_WIDTH(AW), .NUM_REQ(N), .MAX_LOCK(ML)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_write (mem_write),
        .ram_add2  (ram_add2),
        .ram_add1  (ram_add1),
        .ram_wdata (ram_wdata),
        .ram_data1 (ram_data1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] init_word(input int a);
        logic [W-1:0] v;
        v = W'(a) ^ 16'h5A3C;
        if (a == 16'h0010) v = 16'hBEEF;
        return v;
    endfunction

    // RAM: combinational read port, write at the clock edge
    logic [W-1:0] ram [0:65535];
    bit ram_loaded = 1'b0;
    assign ram_data1 = ram[ram_add1];
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int a = 0; a < 65536; a++) ram[a] = init_word(a);
            ram_loaded = 1'b1;
        end
        if (mem_write) ram[ram_add2] = ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: logical memory contents plus a queue of due read returns
    typedef struct { int due; int idx; logic [W-1:0] data; } rd_t;
    rd_t rq[$];
    logic [W-1:0] shadow [0:65535];
    bit  shadow_loaded = 1'b0;
    bit  m_locked = 1'b0;
    int  m_owner = 0, m_cnt = 0, m_ptr = 0;
    logic          e_mw = 1'b0;
    logic [AW-1:0] e_a  = '0;
    logic [W-1:0]  e_wd = '0, e_rdata = '0;

    always @(negedge clk) begin
        int win;
        logic [N-1:0] e_gnt, e_rv;
        logic e_to, we, lk;
        logic [AW-1:0] a;
        logic [W-1:0] d;
        if (!shadow_loaded) begin
            for (int k = 0; k < 65536; k++) shadow[k] = init_word(k);
            shadow_loaded = 1'b1;
        end
        if (!rst) begin
            rq.delete();
            m_locked = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
            e_mw = 1'b0; e_a = '0; e_wd = '0; e_rdata = '0;
            chk("rst_gnt", 32'(bus.gnt), 32'd0);
            chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
            chk("rst_rdata", 32'(bus.rdata), 32'd0);
            chk("rst_lock_timeout", 32'(bus.lock_timeout), 32'd0);
            chk("rst_mem_write", 32'(mem_write), 32'd0);
            chk("rst_ram_add1", 32'(ram_add1), 32'd0);
            chk("rst_ram_add2", 32'(ram_add2), 32'd0);
            chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        end else begin
            e_rv = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_rv    = N'(1) << rq[0].idx;
                e_rdata = rq[0].data;
                void'(rq.pop_front());
            end
            e_to = m_locked && (m_cnt == ML - 1);
            win = -1;
            if (m_locked) begin
                if (bus.req[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (win < 0 && bus.req[c]) win = c;
                end
            end
            e_gnt = (win >= 0) ? (N'(1) << win) : '0;

            chk("gnt", 32'(bus.gnt), 32'(e_gnt));
            chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
            chk("rdata", 32'(bus.rdata), 32'(e_rdata));
            chk("lock_timeout", 32'(bus.lock_timeout), 32'(e_to));
            chk("mem_write", 32'(mem_write), 32'(e_mw));
            chk("ram_add1", 32'(ram_add1), 32'(e_a));
            chk("ram_add2", 32'(ram_add2), 32'(e_a));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));

            // Effects of the coming edge
            lk = 1'b0;
            if (win >= 0) begin
                we = bus.req_we[win];
                lk = bus.req_lock[win];
                a  = bus.req_addr[win*AW +: AW];
                d  = bus.req_wdata[win*W +: W];
                e_mw = we; e_a = a; e_wd = d;
                if (we) shadow[a] = d;
                else rq.push_back('{due: cyc + 2, idx: win, data: shadow[a]});
            end else begin
                e_mw = 1'b0;
            end
            if (m_locked) begin
                if (m_cnt == ML - 1 || (win >= 0 && !lk)) begin
                    m_locked = 1'b0;
                    m_ptr = (m_owner + 1) % N;
                end else begin
                    m_cnt++;
                end
            end else if (win >= 0) begin
                m_ptr = (win + 1) % N;
                if (lk) begin
                    m_locked = 1'b1; m_owner = win; m_cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic lk, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.req[i]              = 1'b1;
        bus.req_we[i]           = we;
        bus.req_lock[i]         = lk;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*W +: W]  = d;
    endtask

    initial begin
        logic [N-1:0] g;
        bus.req = '0; bus.req_we = '0; bus.req_lock = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state
        @(negedge clk);
        chk("reset_gnt", 32'(bus.gnt), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        step(); step();
        rst = 1'b1;

        // Single read by r1
        set_req(1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk); chk("single_gnt", 32'(bus.gnt), 32'b010);
        step(); bus.req = '0;
        step();
        @(negedge clk);
        chk("single_rvalid", 32'(bus.rvalid), 32'b010);
        chk("single_rdata", 32'(bus.rdata), 32'hBEEF);

        // Round-robin from ptr=0
        step(); rst = 1'b0; step(); rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(16'h0020 + i), 16'h0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j < 6) chk("rr_gnt", 32'(bus.gnt), 32'(1 << (j % 3)));
            if (j >= 2) chk("rr_rvalid", 32'(bus.rvalid), 32'(1 << ((j - 2) % 3)));
            step();
            if (j == 5) bus.req = '0;
        end

        // Write then read back by another requester
        set_req(0, 1'b1, 1'b0, 16'h0005, 16'h1234);
        @(negedge clk); chk("wr_gnt", 32'(bus.gnt), 32'b001);
        step(); bus.req = '0; set_req(2, 1'b0, 1'b0, 16'h0005, 16'h0);
        @(negedge clk);
        chk("wr_mem_write", 32'(mem_write), 32'd1);
        chk("wr_ram_add2", 32'(ram_add2), 32'h0005);
        chk("rd2_gnt", 32'(bus.gnt), 32'b100);
        step(); bus.req = '0;
        @(negedge clk); chk("wr_mem_write_off", 32'(mem_write), 32'd0);
        @(negedge clk);
        chk("rd2_rvalid", 32'(bus.rvalid), 32'b100);
        chk("rd2_rdata", 32'(bus.rdata), 32'h1234);
        step();

        // Locked burst by r2 while r0 and r1 wait
        set_req(2, 1'b1, 1'b1, 16'h0040, 16'hA000);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); chk("burst_gnt", 32'(bus.gnt), 32'b100);
            step();
            if (j == 0) begin
                set_req(0, 1'b0, 1'b0, 16'h0041, 16'h0);
                set_req(1, 1'b0, 1'b0, 16'h0042, 16'h0);
            end
            set_req(2, 1'b1, (j < 3), AW'(16'h0041 + j), W'(16'hA001 + j));
            if (j == 4) bus.req[2] = 1'b0;
        end
        @(negedge clk); chk("post_burst_r0", 32'(bus.gnt), 32'b001);
        step(); bus.req[0] = 1'b0;
        @(negedge clk); chk("post_burst_r1", 32'(bus.gnt), 32'b010);
        step(); bus.req = '0;

        // Lock timeout: r1 locks and goes idle, r2 waits
        set_req(1, 1'b0, 1'b1, 16'h0050, 16'h0);
        @(negedge clk); chk("to_lock_gnt", 32'(bus.gnt), 32'b010);
        step(); bus.req = '0; set_req(2, 1'b0, 1'b0, 16'h0051, 16'h0);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            chk("to_pulse", 32'(bus.lock_timeout), 32'(j == 8));
            chk("to_gnt", 32'(bus.gnt), (j == 9) ? 32'b100 : 32'd0);
            step();
        end
        bus.req = '0;
        step();

        // Asynchronous reset with a lock held and a read in flight
        set_req(0, 1'b0, 1'b1, 16'h0010, 16'h0);
        @(negedge clk); chk("ar_gnt", 32'(bus.gnt), 32'b001);
        step(); #1; rst = 1'b0; #1;
        chk("ar_gnt0", 32'(bus.gnt), 32'd0);
        chk("ar_rvalid0", 32'(bus.rvalid), 32'd0);
        chk("ar_rdata0", 32'(bus.rdata), 32'd0);
        chk("ar_mem_write0", 32'(mem_write), 32'd0);
        chk("ar_ram_add1", 32'(ram_add1), 32'd0);
        chk("ar_ram_add2", 32'(ram_add2), 32'd0);
        chk("ar_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("ar_lock_timeout", 32'(bus.lock_timeout), 32'd0);
        step(); rst = 1'b1; bus.req = '0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); chk("ar_no_rvalid", 32'(bus.rvalid), 32'd0);
        end
        step();
        set_req(1, 1'b0, 1'b0, 16'h0060, 16'h0);
        set_req(2, 1'b0, 1'b0, 16'h0061, 16'h0);
        @(negedge clk); chk("ar_unlocked_gnt", 32'(bus.gnt), 32'b010);
        step(); bus.req = '0;

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk); g = bus.gnt;
            step();
            if (n == 1000) rst = 1'b0;
            if (n == 1002) rst = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] || g[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                                AW'($urandom_range(0, 31)), W'($urandom));
                    else
                        bus.req[i] = 1'b0;
                end
            end
        end
        bus.req = '0;
        step(); step(); step();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Arbiter that shares the single RAM instance (one write/read-address port pair, one read-data port) between up to `NUM_REQ` requesters: the interpolation module, the solver core and the host loader. It sits between those masters and the `RAM` module and drives `mem_write`, the write address, the read address and the write data. It returns read data to the owning requester. Arbitration is round-robin with an optional bus lock for multi-word bursts, bounded by a lock timeout.

## Interface
- `WORD_SIZE`, 16, data width
- `ADDRESS_WIDTH`, 16, RAM address width
- `NUM_REQ`, 3, number of requesters (2..8)
- `MAX_LOCK`, 64, maximum cycles a lock may be held
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester access request
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_lock`  in  NUM_REQ  keep ownership after this transfer
- `req_addr`  in  NUM_REQ*ADDRESS_WIDTH  packed addresses, requester i at slice i
- `req_wdata`  in  NUM_REQ*WORD_SIZE  packed write data
- `gnt`  out  NUM_REQ  one-hot grant, combinational
- `rvalid`  out  NUM_REQ  one-hot read-data-valid
- `rdata`  out  WORD_SIZE  read data, broadcast
- `lock_timeout`  out  1  one-cycle pulse on forced lock release
- `mem_write`  out  1  RAM write enable
- `ram_add2`  out  ADDRESS_WIDTH  RAM write address
- `ram_add1`  out  ADDRESS_WIDTH  RAM read address
- `ram_wdata`  out  WORD_SIZE  RAM write data
- `ram_data1`  in  WORD_SIZE  RAM read data, valid one cycle after `ram_add1`

## Operation
- Transfer: a rising edge where `req[i] && gnt[i]`. At most one transfer per cycle.
- Requester fields are sampled at the transfer edge. A requester holds `req` and its fields until it sees `gnt`.
- States:
  - UNLOCKED: grant the first asserted `req` searching from `ptr` upward, modulo `NUM_REQ`. After a transfer by i, `ptr = (i+1) mod NUM_REQ`. A transfer with `req_lock[i]=1` goes to LOCKED with `owner=i` and `lock_cnt=0`.
  - LOCKED: only `owner` can be granted; other requests wait.
    - An owner transfer with `req_lock=0` returns to UNLOCKED and sets `ptr = owner+1`.
    - `lock_cnt` increments every cycle in LOCKED. When it reaches `MAX_LOCK-1`, the block returns to UNLOCKED, sets `ptr = owner+1`, and pulses `lock_timeout` for one cycle.
    - If the owner transfers in that same final cycle, the transfer completes first and the timeout still fires.
- RAM command stage (registered): on a transfer, `ram_add1` and `ram_add2` both take the address, `ram_wdata` takes the data, and `mem_write = req_we[i]`. With no transfer, `mem_write=0` and the addresses and data hold their last values.
- Read return: on a read transfer by i at edge T, the command is on the RAM during cycle T+1. `rvalid[i]=1` and `rdata = ram_data1`, registered, during cycle T+2. Otherwise `rvalid=0` and `rdata` holds its value.
- Back-to-back reads from different requesters pipeline at full rate; rvalid order matches grant order.
- `req` deasserted with `gnt` high: no transfer.

## Timing
- Reset (`rst=0`, asynchronous), all forced to 0:
  - outputs: `gnt`, `rvalid`, `rdata`, `lock_timeout`, `mem_write`, `ram_add1`, `ram_add2`, `ram_wdata`
  - state: UNLOCKED, `ptr`, `lock_cnt`
- `gnt` is gated low while reset is asserted.
- Latency:
  - grant: same cycle as `req` when the requester wins
  - write reaches the RAM: edge T+1
  - read data: `rvalid` during cycle T+2
- Reset mid-lock or mid-read drops the lock. Pending `rvalid` is discarded; no stale pulse after release.

## Structure
- Package `ode_mem_pkg` holds:
  - `arb_state_t` (UNLOCKED, LOCKED)
  - default `NUM_REQ`
  - `MAX_LOCK`
  - requester index constants (`REQ_INTERP=0`, `REQ_SOLVER=1`, `REQ_HOST=2`)
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are the request vector and `ptr`; outputs are the one-hot grant and the winner index.

## Test plan
- Single read: after reset, r1 reads addr 0x0010 (RAM preloaded 0xBEEF) -> `gnt=3'b010` same cycle; `rvalid=3'b010` and `rdata=0xBEEF` two cycles later.
- Round-robin: all three `req` held with reads for 6 cycles, starting from `ptr=0` -> grant sequence 0,1,2,0,1,2; each `rvalid` follows its grant two cycles later.
- Write then read: r0 writes 0x1234 to 0x0005, then r2 reads 0x0005 -> `mem_write=1` for one cycle with `ram_add2=0x0005`; r2 gets 0x1234.
- Lock burst: r2 does 4 locked writes then an unlocked write while r0 and r1 request -> r2 granted 5 consecutive transfers; then r0 and r1 granted in that order.
- Lock timeout: `MAX_LOCK=8`, r1 locks then idles -> `lock_timeout` pulses in the 8th LOCKED cycle; r2 is granted next cycle.
- Async reset: assert `rst` low during a read with a lock held -> all outputs 0 immediately; no `rvalid` after release; state UNLOCKED.
